// File: rtl/alu_4bit_arbiter.sv
// alu_4bit_arbiter: lets two requesters share one external alu_4bit.
// A request is accepted in IDLE. Its operands are then held on the ALU for
// SETTLE_CYCLES cycles, and the sampled result and flags go back to the granted
// requester.
//
// Handshake rule, used on every req/resp channel: a transfer happens on the
// rising clk edge where valid && ready are both high. The source keeps valid
// and its payload stable until that edge. The sink may change ready at any
// time. Dropping valid before the transfer cancels the request.
module alu_4bit_arbiter #(
    parameter int SETTLE_CYCLES  = 1,
    parameter bit FIXED_PRIORITY = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,

    input  logic       r0_req_valid,
    output logic       r0_req_ready,
    input  logic [3:0] r0_req_a,
    input  logic [3:0] r0_req_b,
    input  logic [1:0] r0_req_op,
    output logic       r0_resp_valid,
    input  logic       r0_resp_ready,
    output logic [3:0] r0_resp_result,
    output logic       r0_resp_zero,
    output logic       r0_resp_carry,

    input  logic       r1_req_valid,
    output logic       r1_req_ready,
    input  logic [3:0] r1_req_a,
    input  logic [3:0] r1_req_b,
    input  logic [1:0] r1_req_op,
    output logic       r1_resp_valid,
    input  logic       r1_resp_ready,
    output logic [3:0] r1_resp_result,
    output logic       r1_resp_zero,
    output logic       r1_resp_carry,

    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [1:0] alu_op,
    input  logic [3:0] alu_result,
    input  logic       alu_zero,
    input  logic       alu_carry,

    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // The counter is loaded with SETTLE_CYCLES-1, so a value of 0 means this
    // is the last EXEC cycle.
    localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] cnt;
    logic       grant;
    logic       grant_id;
    logic       last_grant;
    logic       accept;
    logic       settle_done;
    logic       resp_fire;
    logic [3:0] opnd_a;
    logic [3:0] opnd_b;
    logic [1:0] opnd_op;
    logic [3:0] res_q;
    logic       zero_q;
    logic       carry_q;

    // Combinational grant. When both requesters are valid, the winner is r0
    // under fixed priority, otherwise whichever requester was not served last.
    always_comb begin
        grant = 1'b0;
        if (r0_req_valid && r1_req_valid) begin
            grant = FIXED_PRIORITY ? 1'b0 : ~last_grant;
        end else if (r1_req_valid) begin
            grant = 1'b1;
        end
    end

    assign accept       = (state == IDLE) && (r0_req_valid || r1_req_valid);
    assign r0_req_ready = accept && !grant;
    assign r1_req_ready = accept &&  grant;

    assign settle_done  = (state == EXEC) && (cnt == 4'd0);

    // A ready from the requester that does not own the response is ignored.
    assign resp_fire    = (state == RESP) &&
                          (grant_id ? r1_resp_ready : r0_resp_ready);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept)      state_nxt = EXEC;
            EXEC: if (settle_done) state_nxt = RESP;
            RESP: if (resp_fire)   state_nxt = IDLE;
            default:               state_nxt = IDLE;
        endcase
    end

    // Datapath. Operands are latched on accept, the counter runs during EXEC,
    // and the ALU outputs are captured on the last EXEC cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opnd_a     <= 4'd0;
            opnd_b     <= 4'd0;
            opnd_op    <= 2'd0;
            grant_id   <= 1'b0;
            last_grant <= 1'b1;
            cnt        <= 4'd0;
            res_q      <= 4'd0;
            zero_q     <= 1'b0;
            carry_q    <= 1'b0;
        end else begin
            if (accept) begin
                opnd_a     <= grant ? r1_req_a  : r0_req_a;
                opnd_b     <= grant ? r1_req_b  : r0_req_b;
                opnd_op    <= grant ? r1_req_op : r0_req_op;
                grant_id   <= grant;
                last_grant <= grant;
                cnt        <= CNT_LOAD;
            end else if ((state == EXEC) && (cnt != 4'd0)) begin
                cnt <= cnt - 4'd1;
            end
            if (settle_done) begin
                res_q   <= alu_result;
                zero_q  <= alu_zero;
                carry_q <= alu_carry;
            end
        end
    end

    // The ALU is driven only from the operand registers. It therefore keeps
    // its last operands in IDLE and never sees a request before acceptance.
    assign alu_a  = opnd_a;
    assign alu_b  = opnd_b;
    assign alu_op = opnd_op;

    assign r0_resp_valid  = (state == RESP) && !grant_id;
    assign r1_resp_valid  = (state == RESP) &&  grant_id;
    assign r0_resp_result = res_q;
    assign r0_resp_zero   = zero_q;
    assign r0_resp_carry  = carry_q;
    assign r1_resp_result = res_q;
    assign r1_resp_zero   = zero_q;
    assign r1_resp_carry  = carry_q;

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_alu_4bit_arbiter.sv
// Bench for alu_4bit_arbiter. Instance 0 uses the defaults (settle 1,
// round-robin). Instance 1 uses settle 3 and fixed priority. Each instance
// drives its own behavioural alu_4bit.
module tb_alu_4bit_arbiter;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // [instance][requester]
    logic       req_valid   [2][2];
    logic       req_ready   [2][2];
    logic [3:0] req_a       [2][2];
    logic [3:0] req_b       [2][2];
    logic [1:0] req_op      [2][2];
    logic       resp_valid  [2][2];
    logic       resp_ready  [2][2];
    logic [3:0] resp_result [2][2];
    logic       resp_zero   [2][2];
    logic       resp_carry  [2][2];
    // [instance]
    logic [3:0] alu_a      [2];
    logic [3:0] alu_b      [2];
    logic [1:0] alu_op     [2];
    logic [3:0] alu_result [2];
    logic       alu_zero   [2];
    logic       alu_carry  [2];
    logic       busy       [2];

    int n_checks = 0;
    int n_pass   = 0;
    // Operand A the bench last had accepted on each instance.
    logic [3:0] last_a [2];

    // Behavioural alu_4bit. {carry, result}; sub carry = no borrow.
    function automatic logic [4:0] alu_f(input logic [3:0] a, input logic [3:0] b,
                                         input logic [1:0] op);
        case (op)
            2'b00:   alu_f = {1'b0, a} + {1'b0, b};
            2'b01:   alu_f = {(a >= b), a - b};
            2'b10:   alu_f = {1'b0, a & b};
            default: alu_f = {1'b0, a | b};
        endcase
    endfunction

    assign {alu_carry[0], alu_result[0]} = alu_f(alu_a[0], alu_b[0], alu_op[0]);
    assign alu_zero[0] = (alu_result[0] == 4'd0);
    assign {alu_carry[1], alu_result[1]} = alu_f(alu_a[1], alu_b[1], alu_op[1]);
    assign alu_zero[1] = (alu_result[1] == 4'd0);

    alu_4bit_arbiter #(.SETTLE_CYCLES(1), .FIXED_PRIORITY(1'b0)) dut_rr (
        .clk(clk), .rst_n(rst_n),
        .r0_req_valid(req_valid[0][0]), .r0_req_ready(req_ready[0][0]),
        .r0_req_a(req_a[0][0]), .r0_req_b(req_b[0][0]), .r0_req_op(req_op[0][0]),
        .r0_resp_valid(resp_valid[0][0]), .r0_resp_ready(resp_ready[0][0]),
        .r0_resp_result(resp_result[0][0]), .r0_resp_zero(resp_zero[0][0]),
        .r0_resp_carry(resp_carry[0][0]),
        .r1_req_valid(req_valid[0][1]), .r1_req_ready(req_ready[0][1]),
        .r1_req_a(req_a[0][1]), .r1_req_b(req_b[0][1]), .r1_req_op(req_op[0][1]),
        .r1_resp_valid(resp_valid[0][1]), .r1_resp_ready(resp_ready[0][1]),
        .r1_resp_result(resp_result[0][1]), .r1_resp_zero(resp_zero[0][1]),
        .r1_resp_carry(resp_carry[0][1]),
        .alu_a(alu_a[0]), .alu_b(alu_b[0]), .alu_op(alu_op[0]),
        .alu_result(alu_result[0]), .alu_zero(alu_zero[0]), .alu_carry(alu_carry[0]),
        .busy(busy[0])
    );

    alu_4bit_arbiter #(.SETTLE_CYCLES(3), .FIXED_PRIORITY(1'b1)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .r0_req_valid(req_valid[1][0]), .r0_req_ready(req_ready[1][0]),
        .r0_req_a(req_a[1][0]), .r0_req_b(req_b[1][0]), .r0_req_op(req_op[1][0]),
        .r0_resp_valid(resp_valid[1][0]), .r0_resp_ready(resp_ready[1][0]),
        .r0_resp_result(resp_result[1][0]), .r0_resp_zero(resp_zero[1][0]),
        .r0_resp_carry(resp_carry[1][0]),
        .r1_req_valid(req_valid[1][1]), .r1_req_ready(req_ready[1][1]),
        .r1_req_a(req_a[1][1]), .r1_req_b(req_b[1][1]), .r1_req_op(req_op[1][1]),
        .r1_resp_valid(resp_valid[1][1]), .r1_resp_ready(resp_ready[1][1]),
        .r1_resp_result(resp_result[1][1]), .r1_resp_zero(resp_zero[1][1]),
        .r1_resp_carry(resp_carry[1][1]),
        .alu_a(alu_a[1]), .alu_b(alu_b[1]), .alu_op(alu_op[1]),
        .alu_result(alu_result[1]), .alu_zero(alu_zero[1]), .alu_carry(alu_carry[1]),
        .busy(busy[1])
    );

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // ---------------- driver tasks ----------------
    // Waits (bounded) for req_ready (resp=0) or resp_valid (resp=1).
    task automatic wait_high(input int i, input int j, input bit resp, input string tag);
        bit seen = 1'b0;
        for (int w = 0; w < 20; w++) begin
            if (resp ? resp_valid[i][j] : req_ready[i][j]) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk); #1;
        end
        check(tag, 32'(seen), 32'd1);
    endtask

    // One full transaction on instance i, requester j, with hand-computed expectations.
    task automatic do_op(input int i, input int j, input logic [3:0] a, input logic [3:0] b,
                         input logic [1:0] op, input int s, input logic [3:0] e_res,
                         input logic e_z, input logic e_c, input string tag);
        int  n;
        bit  seen;
        req_a[i][j] = a; req_b[i][j] = b; req_op[i][j] = op; req_valid[i][j] = 1'b1;
        #1;
        check({tag, "_alu_a_before_accept"}, 32'(alu_a[i]), 32'(last_a[i]));
        wait_high(i, j, 1'b0, {tag, "_ready"});
        check({tag, "_other_ready"}, 32'(req_ready[i][1-j]), 32'd0);
        @(negedge clk);
        // Operands may change after acceptance; the latched copy must be used.
        req_valid[i][j] = 1'b0; req_a[i][j] = 4'hf; req_b[i][j] = 4'hf; req_op[i][j] = 2'b11;
        #1;
        last_a[i] = a;
        check({tag, "_ready_pulse"}, 32'(req_ready[i][j]), 32'd0);
        n = 1;
        seen = 1'b0;
        while (n <= s + 4) begin
            if (resp_valid[i][j]) begin
                seen = 1'b1;
                break;
            end
            check({tag, "_busy_exec"}, 32'(busy[i]), 32'd1);
            check({tag, "_alu_operands"}, 32'({alu_a[i], alu_b[i], alu_op[i]}), 32'({a, b, op}));
            @(negedge clk); #1;
            n++;
        end
        check({tag, "_resp_seen"}, 32'(seen), 32'd1);
        check({tag, "_latency"}, n, s + 1);
        check({tag, "_result"}, 32'(resp_result[i][j]), 32'(e_res));
        check({tag, "_zero"}, 32'(resp_zero[i][j]), 32'(e_z));
        check({tag, "_carry"}, 32'(resp_carry[i][j]), 32'(e_c));
        check({tag, "_other_resp_valid"}, 32'(resp_valid[i][1-j]), 32'd0);
        check({tag, "_busy_resp"}, 32'(busy[i]), 32'd1);
        resp_ready[i][j] = 1'b1;
        @(negedge clk); #1;
        check({tag, "_resp_drop"}, 32'(resp_valid[i][j]), 32'd0);
        check({tag, "_idle"}, 32'(busy[i]), 32'd0);
        resp_ready[i][j] = 1'b0;
    endtask

    // Both requesters hold valid (r0: 12 AND 10 = 8, r1: 12 OR 10 = 14).
    // The first grant must go to r0; after that grants alternate or stay on r0.
    task automatic contend(input int i, input int rounds, input bit alternate, input string tag);
        int id;
        int exp_id = 0;
        bit seen;
        req_a[i][0] = 4'd12; req_b[i][0] = 4'd10; req_op[i][0] = 2'b10;
        req_a[i][1] = 4'd12; req_b[i][1] = 4'd10; req_op[i][1] = 2'b11;
        resp_ready[i][0] = 1'b1; resp_ready[i][1] = 1'b1;
        req_valid[i][0]  = 1'b1; req_valid[i][1]  = 1'b1;
        #1;
        for (int k = 0; k < rounds; k++) begin
            seen = 1'b0;
            id = 0;
            for (int w = 0; w < 20; w++) begin
                if (req_ready[i][0] || req_ready[i][1]) begin
                    seen = 1'b1;
                    id = req_ready[i][1] ? 1 : 0;
                    break;
                end
                @(negedge clk); #1;
            end
            check({tag, "_grant_seen"}, 32'(seen), 32'd1);
            check({tag, "_grant_id"}, id, exp_id);
            check({tag, "_single_ready"}, 32'(req_ready[i][0] && req_ready[i][1]), 32'd0);
            @(negedge clk); #1;
            wait_high(i, id, 1'b1, {tag, "_resp_seen"});
            check({tag, "_result"}, 32'(resp_result[i][id]), (id == 0) ? 32'd8 : 32'd14);
            if (k == rounds - 1) begin
                req_valid[i][0] = 1'b0;
                req_valid[i][1] = 1'b0;
            end
            @(negedge clk); #1;
            if (alternate) exp_id = 1 - exp_id;
        end
        resp_ready[i][0] = 1'b0;
        resp_ready[i][1] = 1'b0;
        last_a[i] = 4'd12;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        for (int i = 0; i < 2; i++) begin
            last_a[i] = 4'd0;
            for (int j = 0; j < 2; j++) begin
                req_valid[i][j] = 1'b0; req_a[i][j] = 4'd0; req_b[i][j] = 4'd0;
                req_op[i][j] = 2'd0; resp_ready[i][j] = 1'b0;
            end
        end
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            check("reset_busy", 32'(busy[i]), 32'd0);
            check("reset_resp_valid", 32'({resp_valid[i][0], resp_valid[i][1]}), 32'd0);
            check("reset_alu", 32'({alu_a[i], alu_b[i], alu_op[i]}), 32'd0);
            check("reset_result", 32'({resp_result[i][0], resp_zero[i][0], resp_carry[i][0]}), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Single request, then overflow and subtract on r1.
        do_op(0, 0, 4'd5,  4'd3, 2'b00, 1, 4'd8, 1'b0, 1'b0, "single");
        do_op(0, 1, 4'd15, 4'd1, 2'b00, 1, 4'd0, 1'b1, 1'b1, "overflow");
        do_op(0, 1, 4'd5,  4'd5, 2'b01, 1, 4'd0, 1'b1, 1'b1, "sub_zero");

        // Round-robin contention: r0, r1, r0.
        contend(0, 3, 1'b1, "rr");

        // Backpressure: r0 result 3+4=7 held while r1 (9 AND 12 = 8) waits.
        req_a[0][0] = 4'd3; req_b[0][0] = 4'd4; req_op[0][0] = 2'b00; req_valid[0][0] = 1'b1;
        #1;
        wait_high(0, 0, 1'b0, "bp_accept");
        @(negedge clk);
        req_valid[0][0] = 1'b0;
        #1;
        wait_high(0, 0, 1'b1, "bp_resp");
        req_a[0][1] = 4'd9; req_b[0][1] = 4'd12; req_op[0][1] = 2'b10; req_valid[0][1] = 1'b1;
        resp_ready[0][1] = 1'b1;
        #1;
        for (int k = 0; k < 5; k++) begin
            check("bp_hold_valid", 32'(resp_valid[0][0]), 32'd1);
            check("bp_hold_result", 32'({resp_result[0][0], resp_zero[0][0], resp_carry[0][0]}),
                  32'({4'd7, 1'b0, 1'b0}));
            check("bp_r1_no_ready", 32'(req_ready[0][1]), 32'd0);
            check("bp_r1_no_resp", 32'(resp_valid[0][1]), 32'd0);
            @(negedge clk); #1;
        end
        resp_ready[0][0] = 1'b1;
        #1;
        check("bp_valid_before_fire", 32'(resp_valid[0][0]), 32'd1);
        check("bp_r1_no_ready_fire", 32'(req_ready[0][1]), 32'd0);
        @(negedge clk); #1;
        resp_ready[0][0] = 1'b0;
        check("bp_resp_drop", 32'(resp_valid[0][0]), 32'd0);
        check("bp_r1_grant_after_idle", 32'(req_ready[0][1]), 32'd1);
        @(negedge clk);
        req_valid[0][1] = 1'b0;
        #1;
        wait_high(0, 1, 1'b1, "bp_r1_resp");
        check("bp_r1_result", 32'(resp_result[0][1]), 32'd8);
        @(negedge clk); #1;
        resp_ready[0][1] = 1'b0;
        check("bp_r1_idle", 32'(busy[0]), 32'd0);
        last_a[0] = 4'd9;

        // Asynchronous reset in the middle of EXEC (6+2 never returns).
        req_a[0][0] = 4'd6; req_b[0][0] = 4'd2; req_op[0][0] = 2'b00; req_valid[0][0] = 1'b1;
        #1;
        wait_high(0, 0, 1'b0, "rst_accept");
        @(negedge clk);
        req_valid[0][0] = 1'b0;
        #1;
        check("rst_busy_before", 32'(busy[0]), 32'd1);
        check("rst_alu_a_before", 32'(alu_a[0]), 32'd6);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_busy", 32'(busy[0]), 32'd0);
        check("rst_alu", 32'({alu_a[0], alu_b[0], alu_op[0]}), 32'd0);
        check("rst_resp_valid", 32'({resp_valid[0][0], resp_valid[0][1]}), 32'd0);
        check("rst_result", 32'(resp_result[0][0]), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        last_a[0] = 4'd0;
        #1;
        for (int k = 0; k < 4; k++) begin
            check("rst_no_stale_resp", 32'({resp_valid[0][0], resp_valid[0][1], busy[0]}), 32'd0);
            @(negedge clk); #1;
        end
        contend(0, 1, 1'b0, "rr_after_reset");

        // Instance 1: settle 3 (8-3=5), then fixed priority.
        do_op(1, 0, 4'd8, 4'd3, 2'b01, 3, 4'd5, 1'b0, 1'b1, "settle3");
        contend(1, 3, 1'b0, "fixed");
        do_op(1, 1, 4'd2, 4'd1, 2'b00, 3, 4'd3, 1'b0, 1'b0, "fixed_r1_alone");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
